// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and request-check helpers for the load/store unit.
package lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  // Memory write_mode encodings
  typedef enum logic [1:0] {
    WM_NONE = 2'd0,
    WM_BYTE = 2'd1,
    WM_HALF = 2'd2,
    WM_WORD = 2'd3
  } wm_e;

  // Response fault codes
  typedef enum logic [1:0] {
    FAULT_OK         = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_ACCESS     = 2'b10,
    FAULT_ILLEGAL    = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoadWait = 2'd1,
    StStore    = 2'd2,
    StResp     = 2'd3
  } state_e;

  // Checks in priority order: illegal funct3, misalignment, address range.
  function automatic fault_e check_request(input logic        is_store,
                                           input logic [2:0]  funct3,
                                           input logic [31:0] addr,
                                           input logic [31:0] limit);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = (funct3 > F3_WORD);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end
    // funct3[1:0] encodes the access size for every legal load and store
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (illegal) begin
      return FAULT_ILLEGAL;
    end else if (misaligned) begin
      return FAULT_MISALIGNED;
    end else if (addr >= limit) begin
      return FAULT_ACCESS;
    end
    return FAULT_OK;
  endfunction

  function automatic wm_e store_mode(input logic [1:0] size);
    case (size)
      2'b00:   return WM_BYTE;
      2'b01:   return WM_HALF;
      2'b10:   return WM_WORD;
      default: return WM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory signals of the load/store unit.
// master = execute stage plus memory side, slave = the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_address;
  logic [1:0]  mem_write_mode;
  logic [7:0]  mem_write_byte;
  logic [15:0] mem_write_half_word;
  logic [31:0] mem_write_word;
  logic        mem_error;
  logic        mem_done;
  logic [7:0]  mem_byte;
  logic [15:0] mem_half_word;
  logic [31:0] mem_word;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word,
    output mem_error, mem_done, mem_byte, mem_half_word, mem_word
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word,
    input  mem_error, mem_done, mem_byte, mem_half_word, mem_word
  );
endinterface

// File: rtl/load_extender.sv
// load_extender: funct3-driven sign/zero extension of the memory read outputs.
module load_extender
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [7:0]  i_byte,
  input  logic [15:0] i_half_word,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  // Select and extend the memory slice matching the load width
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_BYTE:   o_data = {{24{i_byte[7]}}, i_byte};
      F3_BYTE_U: o_data = {24'd0, i_byte};
      F3_HALF:   o_data = {{16{i_half_word[15]}}, i_half_word};
      F3_HALF_U: o_data = {16'd0, i_half_word};
      F3_WORD:   o_data = i_word;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit in front of a byte-addressable memory.
// Define LSU_TIMEOUT_EN to add a store watchdog that faults after TIMEOUT_CYCLES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT      = 32'h0002_0000,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("load_store_unit: READ_LATENCY must be 1..7 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_e      r_state;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  wm_e         r_wm;
  logic [31:0] r_mem_address;
  logic [2:0]  r_lat_cnt;
  logic [31:0] r_rdata;
  fault_e      r_fault;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  fault_e      r_resp_fault;

`ifdef LSU_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_tmo_cnt;
`endif

  logic        w_req_ready;
  logic        w_accept;
  fault_e      w_check;
  logic [31:0] w_load_data;

  // A store's mem_done must fall before the next request can start
  assign w_req_ready = (r_state == StIdle) && !bus.mem_done;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_check     = check_request(bus.req_is_store, bus.req_funct3, bus.req_addr, MEM_LIMIT);

  load_extender u_load_extender (
    .i_funct3    (r_funct3),
    .i_byte      (bus.mem_byte),
    .i_half_word (bus.mem_half_word),
    .i_word      (bus.mem_word),
    .o_data      (w_load_data)
  );

  // Main FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_funct3      <= '0;
      r_wdata       <= '0;
      r_wm          <= WM_NONE;
      r_mem_address <= '0;
      r_lat_cnt     <= '0;
      r_rdata       <= '0;
      r_fault       <= FAULT_OK;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_fault  <= FAULT_OK;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= FAULT_OK;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_funct3  <= bus.req_funct3;
            r_wdata   <= bus.req_wdata;
            r_lat_cnt <= '0;
            r_rdata   <= '0;
            r_fault   <= w_check;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
            if (w_check != FAULT_OK) begin
              // Faulting requests never touch the memory port
              r_state <= StResp;
            end else begin
              r_mem_address <= bus.req_addr;
              if (bus.req_is_store) begin
                r_wm    <= store_mode(bus.req_funct3[1:0]);
                r_state <= StStore;
              end else begin
                r_state <= StLoadWait;
              end
            end
          end
        end
        StLoadWait: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_rdata <= w_load_data;
            r_state <= StResp;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        StStore: begin
          if (bus.mem_done) begin
            r_wm    <= WM_NONE;
            r_fault <= bus.mem_error ? FAULT_ACCESS : FAULT_OK;
            r_state <= StResp;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_wm    <= WM_NONE;
            r_fault <= FAULT_ACCESS;
            r_state <= StResp;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
`endif
        end
        StResp: begin
          r_resp_valid  <= 1'b1;
          r_resp_rdata  <= (r_fault == FAULT_OK) ? r_rdata : '0;
          r_resp_fault  <= r_fault;
          r_mem_address <= '0;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready           = w_req_ready;
  assign bus.resp_valid          = r_resp_valid;
  assign bus.resp_rdata          = r_resp_rdata;
  assign bus.resp_fault          = r_resp_fault;
  assign bus.mem_address         = r_mem_address;
  assign bus.mem_write_mode      = r_wm;
  assign bus.mem_write_byte      = r_wdata[7:0];
  assign bus.mem_write_half_word = r_wdata[15:0];
  assign bus.mem_write_word      = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven checks of load_store_unit against a small memory model.
module tb_load_store_unit;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
    int          exp_lat;
    logic [1:0]  exp_wm;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NUM_VECS = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_LIMIT      (32'h0002_0000),
    .READ_LATENCY   (2),
    .TIMEOUT_CYCLES (64)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: 256 bytes aliased over the address space, combinational reads,
  // writes complete 3 cycles after write_mode rises, done falls 2 cycles after it drops.
  logic [7:0] mem [256];
  logic       init_done = 1'b0;
  logic       tb_done = 1'b0;
  logic       tb_error = 1'b0;
  logic       err_inject = 1'b0;
  logic       hold_off = 1'b0;
  logic [1:0] wcnt = 2'd0;
  logic       dcnt = 1'b0;
  logic [7:0] a0, a1, a2, a3;

  assign a0 = bus.mem_address[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign bus.mem_byte      = mem[a0];
  assign bus.mem_half_word = {mem[a1], mem[a0]};
  assign bus.mem_word      = {mem[a3], mem[a2], mem[a1], mem[a0]};
  assign bus.mem_done      = tb_done;
  assign bus.mem_error     = tb_error;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h03] <= 8'h80;
      mem[8'hFC] <= 8'h11;
      mem[8'hFD] <= 8'h22;
      mem[8'hFE] <= 8'h33;
      mem[8'hFF] <= 8'h44;
      init_done  <= 1'b1;
    end else if (bus.mem_write_mode != 2'd0 && !tb_done) begin
      if (hold_off) begin
        wcnt <= 2'd0;
      end else if (wcnt == 2'd2) begin
        case (bus.mem_write_mode)
          2'd1: mem[a0] <= bus.mem_write_byte;
          2'd2: begin
            mem[a0] <= bus.mem_write_half_word[7:0];
            mem[a1] <= bus.mem_write_half_word[15:8];
          end
          default: begin
            mem[a0] <= bus.mem_write_word[7:0];
            mem[a1] <= bus.mem_write_word[15:8];
            mem[a2] <= bus.mem_write_word[23:16];
            mem[a3] <= bus.mem_write_word[31:24];
          end
        endcase
        tb_done  <= 1'b1;
        tb_error <= err_inject;
        wcnt     <= 2'd0;
      end else begin
        wcnt <= wcnt + 2'd1;
      end
    end else if (tb_done && bus.mem_write_mode == 2'd0) begin
      if (dcnt) begin
        tb_done  <= 1'b0;
        tb_error <= 1'b0;
        dcnt     <= 1'b0;
      end else begin
        dcnt <= 1'b1;
      end
    end else begin
      wcnt <= 2'd0;
    end
  end

  // Response monitor
  int   resp_cnt = 0;
  int   dbl_cnt = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      if (prev_valid) dbl_cnt <= dbl_cnt + 1;
    end
    prev_valid <= bus.resp_valid;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // lat counts edges after acceptance until resp_valid is seen; -2 = never accepted, -1 = no resp.
  task automatic send(input vec_t v, output int lat, output logic [31:0] rd,
                      output logic [1:0] fl, output logic [1:0] wm0, output logic [31:0] ad0,
                      output logic [31:0] wd0);
    bit ok;
    err_inject       = v.err;
    bus.req_is_store = v.st;
    bus.req_funct3   = v.f3;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
    wait_accept(ok);
    bus.req_valid = 1'b0;
    wm0 = bus.mem_write_mode;
    ad0 = bus.mem_address;
    wd0 = bus.mem_write_word;
    lat = -2;
    rd  = '0;
    fl  = '0;
    if (ok) begin
      lat = -1;
      for (int k = 0; k < 300; k++) begin
        if (bus.resp_valid) begin
          lat = k;
          rd  = bus.resp_rdata;
          fl  = bus.resp_fault;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  vec_t vecs [NUM_VECS];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          found;
    int          r0;
    bit          ok;
    logic [31:0] rd, ad0, wd0;
    logic [1:0]  fl, wm0;
    vec_t        v;

    //             st    f3      addr           wdata          err   rdata          flt    lat wm    addr
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         1'b0, 32'hFFFF_FF80, 2'b00, 3, 2'd0, 32'h103};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_0080, 2'b00, 3, 2'd0, 32'h103};
    vecs[2]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         2'b00, 5, 2'd3, 32'h10};
    vecs[3]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2'b00, 3, 2'd0, 32'h10};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_DEAD, 2'b00, 3, 2'd0, 32'h12};
    vecs[5]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_DEAD, 2'b00, 3, 2'd0, 32'h12};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_0005, 32'h0,         1'b0, 32'h0,         2'b01, 1, 2'd0, 32'h0};
    vecs[7]  = '{1'b1, 3'b000, 32'h0002_0000, 32'h0000_00FF, 1'b0, 32'h0,         2'b10, 1, 2'd0, 32'h0};
    vecs[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         2'b11, 1, 2'd0, 32'h0};
    vecs[9]  = '{1'b1, 3'b000, 32'h0000_0021, 32'h1234_5677, 1'b0, 32'h0,         2'b00, 5, 2'd1, 32'h21};
    vecs[10] = '{1'b0, 3'b000, 32'h0000_0021, 32'h0,         1'b0, 32'h0000_0077, 2'b00, 3, 2'd0, 32'h21};
    vecs[11] = '{1'b1, 3'b011, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         2'b11, 1, 2'd0, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         2'b11, 1, 2'd0, 32'h0};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b0, 32'h0,         2'b01, 1, 2'd0, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 32'h0001_FFFC, 32'h0,         1'b0, 32'h4433_2211, 2'b00, 3, 2'd0, 32'h1FFFC};
    vecs[15] = '{1'b0, 3'b010, 32'h0002_0000, 32'h0,         1'b0, 32'h0,         2'b10, 1, 2'd0, 32'h0};
    vecs[16] = '{1'b0, 3'b111, 32'h0000_0001, 32'h0,         1'b0, 32'h0,         2'b11, 1, 2'd0, 32'h0};
    vecs[17] = '{1'b0, 3'b001, 32'h0003_0001, 32'h0,         1'b0, 32'h0,         2'b01, 1, 2'd0, 32'h0};
    vecs[18] = '{1'b1, 3'b001, 32'h0000_0030, 32'hAAAA_8001, 1'b0, 32'h0,         2'b00, 5, 2'd2, 32'h30};
    vecs[19] = '{1'b0, 3'b001, 32'h0000_0030, 32'h0,         1'b0, 32'hFFFF_8001, 2'b00, 3, 2'd0, 32'h30};
    vecs[20] = '{1'b1, 3'b010, 32'h0000_0050, 32'h0000_0001, 1'b1, 32'h0,         2'b10, 5, 2'd3, 32'h50};
    vecs[21] = '{1'b0, 3'b100, 32'h0000_0031, 32'h0,         1'b0, 32'h0000_0080, 2'b00, 3, 2'd0, 32'h31};

    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_write_mode", 32'(bus.mem_write_mode), 32'd0);
    check("rst_address", bus.mem_address, 32'd0);
    check("rst_write_word", bus.mem_write_word, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) begin
      send(vecs[i], lat, rd, fl, wm0, ad0, wd0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_fault", i), 32'(fl), 32'(vecs[i].exp_fault));
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_write_mode", i), 32'(wm0), 32'(vecs[i].exp_wm));
      check($sformatf("v%0d_address", i), ad0, vecs[i].exp_addr);
      if (vecs[i].exp_wm != 2'd0) check($sformatf("v%0d_write_word", i), wd0, vecs[i].wdata);
    end

    // Two SH requests held valid back-to-back
    repeat (3) @(negedge clk);
    r0 = resp_cnt;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b001;
    bus.req_addr     = 32'h60;
    bus.req_wdata    = 32'h0000_1234;
    bus.req_valid    = 1'b1;
    wait_accept(ok);
    check("b2b_first_accept", 32'(ok), 32'd1);
    bus.req_addr  = 32'h62;
    bus.req_wdata = 32'h0000_5678;
    found = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.req_ready) begin
        found = k;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_second_accept_cycle", found, 32'd6);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("b2b_second_resp_latency", lat, 32'd5);
    repeat (3) @(negedge clk);
    check("b2b_resp_count", 32'(resp_cnt - r0), 32'd2);
    v = '{1'b0, 3'b010, 32'h60, 32'h0, 1'b0, 32'h5678_1234, 2'b00, 3, 2'd0, 32'h60};
    send(v, lat, rd, fl, wm0, ad0, wd0);
    check("b2b_readback", rd, v.exp_rdata);

    // Reset pulse during a store, just as the memory raises done
    repeat (3) @(negedge clk);
    r0 = resp_cnt;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h40;
    bus.req_wdata    = 32'hCAFE_F00D;
    bus.req_valid    = 1'b1;
    wait_accept(ok);
    bus.req_valid = 1'b0;
    check("rst_store_accept", 32'(ok), 32'd1);
    check("rst_store_wm_before", 32'(bus.mem_write_mode), 32'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_store_wm_after", 32'(bus.mem_write_mode), 32'd0);
    check("rst_store_address", bus.mem_address, 32'd0);
    check("rst_store_write_word", bus.mem_write_word, 32'd0);
    check("rst_store_resp_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_store_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_store_ready_k3", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rst_store_ready_k4", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rst_store_ready_k5", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_store_no_resp", 32'(resp_cnt - r0), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // Memory never completes: watchdog must fault the store
    hold_off = 1'b1;
    v = '{1'b1, 3'b010, 32'h70, 32'h1111_2222, 1'b0, 32'h0, 2'b10, 65, 2'd3, 32'h70};
    send(v, lat, rd, fl, wm0, ad0, wd0);
    check("tmo_latency", lat, 32'd65);
    check("tmo_fault", 32'(fl), 32'(v.exp_fault));
    check("tmo_wm_released", 32'(bus.mem_write_mode), 32'd0);
    hold_off = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("no_back_to_back_resp", 32'(dbl_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the `byte_addressable` data memory. It accepts one RISC-V load or store request at a time and checks alignment, width encoding and address range. It drives the memory's `address`/`write_mode` interface and follows its write handshake, then returns a one-cycle response carrying sign- or zero-extended load data or a fault code.

## Interface
- `MEM_LIMIT`, default 32'h0002_0000: first out-of-range byte address; accesses at or above it fault without touching memory.
- `READ_LATENCY`, default 2: cycles from address presented to valid `byte_output`/`half_word_output`/`word_output`; legal range 1–7.
- `TIMEOUT_CYCLES`, default 64: store watchdog limit; used only with `LSU_TIMEOUT_EN`.
- Clock/reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte or halfword is used for SB/SH.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- `mem_address`  out  32  to memory `address`.
- `mem_write_mode`  out  2  to memory `write_mode`: 0 none, 1 byte, 2 half, 3 word.
- `mem_write_byte` / `mem_write_half_word` / `mem_write_word`  out  8/16/32  slices of the latched `req_wdata`.
- `mem_error`, `mem_done`  in  1 each  from memory.
- `mem_byte`, `mem_half_word`, `mem_word`  in  8/16/32  memory read outputs.

## Operation
- Request acceptance:
  - `req_ready = (state == IDLE) && !mem_done`.
  - A request is accepted on an edge where `req_valid && req_ready`.
  - `req_addr`, `req_funct3`, `req_is_store` and `req_wdata` are latched on acceptance.
- Checks on the latched request, in priority order:
  1. Illegal funct3: loads 011/110/111; stores with funct3 > 010. Response code 11.
  2. Misaligned: half with `addr[0]`≠0; word with `addr[1:0]`≠0. Response code 01.
  3. Out of range: `addr >= MEM_LIMIT`. Response code 10.
  - Any failed check sends the FSM to RESP with no memory activity; `mem_write_mode` stays 0.
- FSM states:
  - IDLE: on acceptance, go to RESP if any check fails, else LOAD_WAIT or STORE.
  - LOAD_WAIT: counts `READ_LATENCY` cycles, then samples memory data and goes to RESP.
  - STORE: drives `mem_write_mode` (SB 1, SH 2, SW 3) until `mem_done` is sampled high. Latches `mem_error` into code 10, then goes to RESP.
  - RESP: pulses `resp_valid`, then goes to IDLE.
- Load extension:
  - LB/LBU: sign/zero-extend `mem_byte`.
  - LH/LHU: sign/zero-extend `mem_half_word`.
  - LW: `mem_word`.
- `mem_address` holds the latched address from acceptance until return to IDLE. It is 0 in IDLE.
- `mem_write_mode` is 0 in every state except STORE.

## Timing
- Acceptance is at edge A.
- Fault path: `resp_valid` is high in the cycle after edge A+1.
- Load: `resp_valid` is high in the cycle after edge A+READ_LATENCY+1.
- Store:
  - `mem_write_mode` is nonzero from edge A until the edge where `mem_done` is sampled high.
  - `resp_valid` is high one cycle after that edge.
  - The next request waits for `mem_done` to fall, which the memory does 2 cycles after `write_mode` drops. Back-to-back stores are therefore throttled by `req_ready`.
- Reset values: state IDLE, all memory drive outputs 0, `resp_valid` 0, `resp_rdata` 0, `resp_fault` 00.
- Reset mid-store: `mem_write_mode` drops to 0 immediately. The memory may still finish the write. `req_ready` stays low until `mem_done` is 0.
- `resp_valid` is never high two consecutive cycles.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter runs in STORE and reports code 10 if `mem_done` has not risen after `TIMEOUT_CYCLES` cycles.
  - On timeout, `mem_write_mode` is released and the FSM goes to RESP.
- `LSU_TIMEOUT_EN` undefined: STORE waits indefinitely and no counter is synthesised.

## Structure
- Package `lsu_pkg`:
  - funct3 constants.
  - Write-mode encodings (`WM_NONE`, `WM_BYTE`, `WM_HALF`, `WM_WORD`).
  - Fault codes.
  - FSM state encoding.
- Sub-module `load_extender`: combinational funct3-driven sign/zero extension of the memory outputs, instantiated once.

## Test plan
- LB at 0x0000_0103, memory byte 0x80 → `resp_rdata` 0xFFFF_FF80, code 00; LBU at the same address → 0x0000_0080.
- SW at 0x0000_0010, data 0xDEAD_BEEF → `mem_write_mode`=3 until `mem_done`, response code 00; a following LW at 0x10 returns 0xDEAD_BEEF.
- LH at 0x0000_0005 → code 01 at A+1; `mem_write_mode` and `mem_address` never change.
- SB at 0x0002_0000 → code 10, no write; LW funct3 011 → code 11.
- Two SH requests held valid back-to-back → second accepted only after `mem_done` falls; each gets exactly one `resp_valid`.
- `rst_n` low for one cycle during STORE → `mem_write_mode` 0 next cycle, outputs at reset values, `req_ready` low until `mem_done` is 0. With `LSU_TIMEOUT_EN` and `mem_done` tied 0 → code 10 after 64 cycles.
